axi_rd_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI read port (AR and R channels) of a DDR4/HBM memory channel between NUM_M benchmark read engines. Each AR request is registered and issued downstream in grant order. The grant index is recorded in an in-order route FIFO, and R beats are steered back to the owning engine. It sits between the per-engine read generators and the memory-controller AXI slave, with the write channels bypassing it.

---
 rtl/axi_rd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter sharing one AXI read port (AR + R)
// between NUM_M read engines. Grants are recorded in an in-order route FIFO
// so that R bursts are steered back to the engine that issued them.
// Optional build macro: AXI_ARB_QOS_EN selects the highest m_arqos among
// valid requesters, with round-robin order from rr_ptr breaking ties.
module axi_rd_arbiter #(
  parameter int NUM_M       = 4,
  parameter int ADDR_WIDTH  = 33,
  parameter int DATA_WIDTH  = 512,
  parameter int OUTSTANDING = 16
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic [NUM_M*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_M*8-1:0]          m_arlen,
  input  logic [NUM_M*4-1:0]          m_arqos,
  input  logic [NUM_M-1:0]            m_arvalid,
  output logic [NUM_M-1:0]            m_arready,
  output logic [DATA_WIDTH-1:0]       m_rdata,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic [NUM_M-1:0]            m_rvalid,
  input  logic [NUM_M-1:0]            m_rready,
  output logic [ADDR_WIDTH-1:0]       s_araddr,
  output logic [7:0]                  s_arlen,
  output logic [2:0]                  s_arsize,
  output logic [1:0]                  s_arburst,
  output logic                        s_arid,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  input  logic [DATA_WIDTH-1:0]       s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rlast,
  input  logic                        s_rvalid,
  output logic                        s_rready
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {ARB, ISSUE} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             grant;

  logic [IDX_W-1:0] route_mem [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full, fifo_empty, pop;
  logic [IDX_W-1:0] head;

  logic [ADDR_WIDTH-1:0] req_addr [NUM_M];
  logic [7:0]            req_len  [NUM_M];

  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign req_addr[i] = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_len[i]  = m_arlen[i*8 +: 8];
  end

`ifdef AXI_ARB_QOS_EN
  logic [3:0] req_qos [NUM_M];
  logic [3:0] best_qos;

  for (genvar i = 0; i < NUM_M; i++) begin : g_qos
    assign req_qos[i] = m_arqos[i*4 +: 4];
  end

  // Winner = highest QoS; strict '>' keeps the earliest candidate in rr order on ties
  always_comb begin
    cand     = rr_ptr;
    found    = 1'b0;
    win      = '0;
    best_qos = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (m_arvalid[cand] && (!found || (req_qos[cand] > best_qos))) begin
        found    = 1'b1;
        win      = cand;
        best_qos = req_qos[cand];
      end
      cand = (cand == IDX_W'(NUM_M-1)) ? '0 : cand + 1'b1;
    end
  end
`else
  logic unused_qos;
  assign unused_qos = ^m_arqos;

  // Winner = first valid requester walking from rr_ptr, wrapping at NUM_M
  always_comb begin
    cand  = rr_ptr;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (m_arvalid[cand] && !found) begin
        found = 1'b1;
        win   = cand;
      end
      cand = (cand == IDX_W'(NUM_M-1)) ? '0 : cand + 1'b1;
    end
  end
`endif

  // Next-state logic: grant only from ARB while the route FIFO has room
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    case (state)
      ARB: begin
        if (found && !fifo_full) begin
          grant      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (s_arready) next_state = ARB;
      end
      default: next_state = ARB;
    endcase
  end

  // The grant pulse is held low while reset is asserted
  assign m_arready = (grant && arstn) ? (NUM_M'(1) << win) : '0;
  assign s_arvalid = (state == ISSUE);
  assign s_arsize  = 3'($clog2(DATA_WIDTH/8));
  assign s_arburst = 2'b01;
  assign s_arid    = 1'b0;

  // State, rr pointer and the captured AR fields of the winner
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= ARB;
      rr_ptr   <= '0;
      s_araddr <= '0;
      s_arlen  <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        rr_ptr   <= (win == IDX_W'(NUM_M-1)) ? '0 : win + 1'b1;
        s_araddr <= req_addr[win];
        s_arlen  <= req_len[win];
      end
    end
  end

  assign fifo_full  = (count == (PTR_W+1)'(OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head       = route_mem[rd_ptr];
  assign pop        = s_rvalid & s_rready & s_rlast;

  // Route FIFO storage; entries are only read while the occupancy says valid
  always_ff @(posedge clk) begin
    if (grant) route_mem[wr_ptr] <= win;
  end

  // Route FIFO pointers and occupancy; push and pop together hold the count
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // R channel steering to the FIFO head owner; payload is broadcast
  assign s_rready = !fifo_empty && m_rready[head];
  assign m_rvalid = (!fifo_empty && s_rvalid) ? (NUM_M'(1) << head) : '0;
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_rlast  = s_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: a table of grant vectors plus
// directed sequences for bursts, FIFO limit, backpressure, reset and QoS.
module tb_axi_rd_arbiter;

  localparam int NUM_M       = 4;
  localparam int ADDR_WIDTH  = 33;
  localparam int DATA_WIDTH  = 512;
  localparam int OUTSTANDING = 16;

  logic                        clk = 1'b0;
  logic                        arstn = 1'b0;
  logic [NUM_M*ADDR_WIDTH-1:0] m_araddr;
  logic [NUM_M*8-1:0]          m_arlen;
  logic [NUM_M*4-1:0]          m_arqos;
  logic [NUM_M-1:0]            m_arvalid;
  logic [NUM_M-1:0]            m_arready;
  logic [DATA_WIDTH-1:0]       m_rdata;
  logic [1:0]                  m_rresp;
  logic                        m_rlast;
  logic [NUM_M-1:0]            m_rvalid;
  logic [NUM_M-1:0]            m_rready;
  logic [ADDR_WIDTH-1:0]       s_araddr;
  logic [7:0]                  s_arlen;
  logic [2:0]                  s_arsize;
  logic [1:0]                  s_arburst;
  logic                        s_arid;
  logic                        s_arvalid;
  logic                        s_arready;
  logic [DATA_WIDTH-1:0]       s_rdata;
  logic [1:0]                  s_rresp;
  logic                        s_rlast;
  logic                        s_rvalid;
  logic                        s_rready;

  axi_rd_arbiter #(
    .NUM_M(NUM_M), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk(clk), .arstn(arstn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arqos(m_arqos),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arid(s_arid),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int w, gcount, beats, b;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] gnt;
  } vec_t;
  vec_t tbl [12];

  logic rdy_pat [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m_arvalid = '0;
    m_arqos   = '0;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    s_rlast   = 1'b0;
    s_rvalid  = 1'b0;
  endtask

  task automatic set_req_fields();
    for (int i = 0; i < NUM_M; i++) begin
      m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(32'h1000 * (i + 1));
      m_arlen[i*8 +: 8] = 8'(i);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    arstn = 1'b0;
    cyc();
    cyc();
    arstn = 1'b1;
    settle();
  endtask

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_araddr = '0;
    m_arlen  = '0;
    idle_inputs();

    // ---------------- reset state ----------------
    cyc();
    s_rvalid = 1'b1;
    m_rready = '1;
    settle();
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_araddr", s_araddr, 0);
    check("rst_s_arlen", s_arlen, 0);
    check("rst_m_arready", m_arready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_s_rready", s_rready, 0);
    do_reset();
    s_rvalid = 1'b1;
    m_rready = '1;
    settle();
    check("post_rst_m_rvalid", m_rvalid, 0);
    check("post_rst_s_rready", s_rready, 0);
    check("s_arsize", s_arsize, 6);
    check("s_arburst", s_arburst, 1);
    check("s_arid", s_arid, 0);
    idle_inputs();

    // ---------------- table: round-robin grant vectors ----------------
    tbl[0]  = '{4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1010, 4'b0010};
    tbl[5]  = '{4'b1010, 4'b1000};
    tbl[6]  = '{4'b0001, 4'b0001};
    tbl[7]  = '{4'b0001, 4'b0001};
    tbl[8]  = '{4'b1100, 4'b0100};
    tbl[9]  = '{4'b0110, 4'b0010};
    tbl[10] = '{4'b1001, 4'b1000};
    tbl[11] = '{4'b0000, 4'b0000};
    set_req_fields();
    for (int n = 0; n < 12; n++) begin
      m_arvalid = tbl[n].vld;
      settle();
      check($sformatf("tbl%0d_arready", n), m_arready, tbl[n].gnt);
      cyc();
      m_arvalid = '0;
      settle();
      if (tbl[n].gnt != 4'b0000) begin
        w = 0;
        for (int i = 0; i < NUM_M; i++) if (tbl[n].gnt[i]) w = i;
        check($sformatf("tbl%0d_s_arvalid", n), s_arvalid, 1);
        check($sformatf("tbl%0d_s_araddr", n), s_araddr, 64'(32'h1000 * (w + 1)));
        check($sformatf("tbl%0d_s_arlen", n), s_arlen, 64'(w));
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b1;
        m_rready  = '1;
        settle();
        check($sformatf("tbl%0d_m_rvalid", n), m_rvalid, tbl[n].gnt);
        check($sformatf("tbl%0d_s_rready", n), s_rready, 1);
        cyc();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = '0;
      end else begin
        check($sformatf("tbl%0d_idle_s_arvalid", n), s_arvalid, 0);
      end
    end

    // ---------------- single requester 0, 8-beat burst ----------------
    do_reset();
    m_araddr = '0;
    m_arlen  = '0;
    m_araddr[ADDR_WIDTH-1:0] = 33'h100;
    m_arlen[7:0] = 8'd7;
    m_arvalid = 4'b0001;
    settle();
    check("single_arready", m_arready, 4'b0001);
    cyc();
    m_arvalid = '0;
    settle();
    check("single_arready_pulse", m_arready, 0);
    check("single_s_arvalid", s_arvalid, 1);
    check("single_s_araddr", s_araddr, 64'h100);
    check("single_s_arlen", s_arlen, 7);
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0;
    settle();
    check("single_s_arvalid_drop", s_arvalid, 0);
    m_rready = 4'b0001;
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      s_rvalid = 1'b1;
      s_rlast  = (k == 7);
      s_rdata  = DATA_WIDTH'(64'hA000 + k);
      settle();
      check($sformatf("single_rvalid%0d", k), m_rvalid, 4'b0001);
      check($sformatf("single_rlast%0d", k), m_rlast, (k == 7));
      check($sformatf("single_rdata%0d", k), m_rdata[63:0], 64'hA000 + k);
      if (m_rvalid[0] && s_rready) beats++;
      cyc();
    end
    s_rlast = 1'b0;
    settle();
    check("single_no_extra_rvalid", m_rvalid, 0);
    check("single_beats", beats, 8);
    idle_inputs();

    // ---------------- all valid: order, FIFO limit, drain order ----------------
    do_reset();
    set_req_fields();
    m_arvalid = '1;
    s_arready = 1'b1;
    gcount = 0;
    for (int c = 0; c < 50; c++) begin
      settle();
      if (|m_arready) begin
        check($sformatf("order%0d", gcount), m_arready, 64'(4'b0001 << (gcount % 4)));
        gcount++;
      end
      cyc();
    end
    check("full_grant_count", gcount, 16);
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    m_rready = '1;
    settle();
    check("full_still_blocked", m_arready, 0);
    check("full_pop_m_rvalid", m_rvalid, 4'b0001);
    check("full_pop_s_rready", s_rready, 1);
    cyc();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    gcount = 0;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (|m_arready) begin
        check("refill_grant", m_arready, 4'b0001);
        gcount++;
      end
      cyc();
    end
    check("refill_grant_count", gcount, 1);
    m_arvalid = '0;
    for (int k = 0; k < 16; k++) begin
      s_rvalid = 1'b1;
      s_rlast  = 1'b1;
      settle();
      check($sformatf("drain%0d", k), m_rvalid, 64'(4'b0001 << ((k + 1) % 4)));
      cyc();
    end
    settle();
    check("drain_empty", m_rvalid, 0);
    idle_inputs();

    // ---------------- requester 2 backpressure ----------------
    do_reset();
    set_req_fields();
    m_arvalid = 4'b0100;
    settle();
    check("bp_arready", m_arready, 4'b0100);
    cyc();
    m_arvalid = '0;
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    b = 0;
    for (int c = 0; c < 6; c++) begin
      s_rvalid = 1'b1;
      s_rdata  = DATA_WIDTH'(64'hB0 + b);
      s_rlast  = (b == 2);
      m_rready = rdy_pat[c] ? 4'b1111 : 4'b1011;
      settle();
      check($sformatf("bp_rvalid%0d", c), m_rvalid, 4'b0100);
      check($sformatf("bp_s_rready%0d", c), s_rready, rdy_pat[c]);
      check($sformatf("bp_rdata%0d", c), m_rdata[63:0], 64'hB0 + b);
      if (rdy_pat[c]) b++;
      cyc();
    end
    s_rlast  = 1'b0;
    m_rready = '1;
    settle();
    check("bp_popped", m_rvalid, 0);
    idle_inputs();

    // ---------------- reset during ISSUE ----------------
    do_reset();
    set_req_fields();
    m_arvalid = 4'b0111;
    s_arready = 1'b1;
    for (int c = 0; c < 6; c++) cyc();
    m_arvalid = 4'b1000;
    s_arready = 1'b0;
    settle();
    check("mid_grant3", m_arready, 4'b1000);
    cyc();
    settle();
    check("mid_issue", s_arvalid, 1);
    s_rvalid = 1'b1;
    m_rready = '1;
    settle();
    check("mid_head0", m_rvalid, 4'b0001);
    arstn = 1'b0;
    settle();
    check("mid_rst_s_arvalid", s_arvalid, 0);
    check("mid_rst_m_rvalid", m_rvalid, 0);
    check("mid_rst_s_rready", s_rready, 0);
    check("mid_rst_s_araddr", s_araddr, 0);
    check("mid_rst_m_arready", m_arready, 0);
    cyc();
    arstn = 1'b1;
    m_arvalid = '1;
    settle();
    check("mid_after_rr0", m_arready, 4'b0001);
    check("mid_after_no_rvalid", m_rvalid, 0);
    cyc();
    settle();
    check("mid_after_addr", s_araddr, 64'h1000);
    idle_inputs();

`ifdef AXI_ARB_QOS_EN
    // ---------------- QoS arbitration ----------------
    do_reset();
    set_req_fields();
    m_arqos   = {4'd3, 4'd9, 4'd9, 4'd1};
    m_arvalid = '1;
    s_arready = 1'b1;
    s_rvalid  = 1'b1;
    s_rlast   = 1'b1;
    m_rready  = '1;
    gcount = 0;
    for (int c = 0; c < 14; c++) begin
      settle();
      if (|m_arready) begin
        check($sformatf("qos%0d", gcount), m_arready,
              (gcount % 2 == 0) ? 64'(4'b0010) : 64'(4'b0100));
        gcount++;
      end
      cyc();
    end
    check("qos_count", gcount, 7);
    idle_inputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
